// File: rtl/spi_frame_controller.sv
// spi_frame_controller: runs CMD/LEN framed register reads and writes popped from the SPI RX FIFO
// Ports: clk, rst (sync, active-high); rx_empty/rx_rd/rx_data = RX FIFO pop side;
//        tx_full/tx_wr/tx_data = TX FIFO push side; reg_addr/reg_wdata/reg_we/reg_re/reg_rdata = register bus;
//        busy = FSM not idle; timeout_err = sticky stall-abort flag, cleared by err_clr.
// Optional: define SPI_FRAME_CTRL_ACK_EN to push 0xA5 and the final address after every write frame.
module spi_frame_controller #(
    parameter int FIFO_RD_LAT = 1,
    parameter int REG_RD_LAT  = 1,
    parameter int TIMEOUT     = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    output logic       rx_rd,
    input  logic [7:0] rx_data,
    input  logic       tx_full,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       timeout_err,
    input  logic       err_clr
);
    typedef enum logic [3:0] {IDLE, GET_LEN, WR_DATA, RD_REQ, RD_WAIT, TX_PUSH, DONE, ACK_HDR, ACK_ADDR} state_t;
    state_t      state, state_n;
    logic        pend, pend_n, cmd_wr, cmd_wr_n;
    logic [7:0]  dly, dly_n, cnt, cnt_n, rdata, rdata_n, wdata_n, tx_data_n;
    logic [6:0]  addr_n;
    logic [15:0] tout, tout_n;
    logic        err_n, rx_rd_n, tx_wr_n, reg_we_n, reg_re_n;
    logic        got, pop_ok, stall, act;

    assign busy = state != IDLE;

    always_comb begin
        state_n   = state;
        pend_n    = pend;
        dly_n     = dly != 8'd0 ? dly - 8'd1 : dly;
        cmd_wr_n  = cmd_wr;
        cnt_n     = cnt;
        addr_n    = (reg_we || reg_re) ? reg_addr + 7'd1 : reg_addr;
        wdata_n   = reg_wdata;
        rdata_n   = rdata;
        tx_data_n = tx_data;
        err_n     = err_clr ? 1'b0 : timeout_err;
        rx_rd_n   = 1'b0;
        tx_wr_n   = 1'b0;
        reg_we_n  = 1'b0;
        reg_re_n  = 1'b0;
        stall     = 1'b0;
        act       = rx_rd || tx_wr || reg_we || reg_re;
        tout_n    = tout;
        // a popped byte is on rx_data once the latency countdown expires
        got       = pend && dly == 8'd0;
        pop_ok    = !pend && !rx_empty;
        if (got) pend_n = 1'b0;
        case (state)
            IDLE: begin
                if (got) begin
                    cmd_wr_n = rx_data[7];
                    addr_n   = rx_data[6:0];
                    state_n  = GET_LEN;
                end else rx_rd_n = pop_ok;
            end
            GET_LEN: begin
                if (got) begin
                    cnt_n   = rx_data;
                    state_n = rx_data == 8'd0 ? DONE : cmd_wr ? WR_DATA : RD_REQ;
                end else if (!pend) begin
                    stall   = rx_empty;
                    rx_rd_n = !rx_empty;
                end
            end
            WR_DATA: begin
                // the next pop may be issued while the previous write strobe is out
                if (reg_we && cnt == 8'd0) state_n = DONE;
                else if (got) begin
                    wdata_n  = rx_data;
                    reg_we_n = 1'b1;
                    cnt_n    = cnt - 8'd1;
                end else if (!pend) begin
                    stall   = rx_empty;
                    rx_rd_n = !rx_empty;
                end
            end
            RD_REQ: begin
                reg_re_n = 1'b1;
                state_n  = RD_WAIT;
            end
            RD_WAIT: begin
                if (dly == 8'd0) begin
                    rdata_n = reg_rdata;
                    cnt_n   = cnt - 8'd1;
                    state_n = TX_PUSH;
                end
            end
            TX_PUSH: begin
                // leave only after the push cycle so tx_full reflects our own write
                if (tx_wr) state_n = cnt == 8'd0 ? DONE : RD_REQ;
                else if (tx_full) stall = 1'b1;
                else begin
                    tx_wr_n   = 1'b1;
                    tx_data_n = rdata;
                end
            end
            DONE: begin
`ifdef SPI_FRAME_CTRL_ACK_EN
                state_n = cmd_wr ? ACK_HDR : IDLE;
`else
                state_n = IDLE;
`endif
            end
            ACK_HDR: begin
                if (tx_wr) state_n = ACK_ADDR;
                else if (tx_full) stall = 1'b1;
                else begin
                    tx_wr_n   = 1'b1;
                    tx_data_n = 8'hA5;
                end
            end
            ACK_ADDR: begin
                if (tx_wr) state_n = IDLE;
                else if (tx_full) stall = 1'b1;
                else begin
                    tx_wr_n   = 1'b1;
                    tx_data_n = {1'b0, reg_addr};
                end
            end
            default: state_n = IDLE;
        endcase
        if (rx_rd_n) begin
            pend_n = 1'b1;
            dly_n  = 8'(FIFO_RD_LAT);
        end
        if (reg_re_n) dly_n = 8'(REG_RD_LAT);
        if (act) tout_n = 16'd0;
        else if (stall) tout_n = tout + 16'd1;
        if (stall && !act && tout == 16'(TIMEOUT - 1)) begin
            state_n = IDLE;
            pend_n  = 1'b0;
            err_n   = 1'b1;
            tout_n  = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= 1'b0;
            dly         <= 8'd0;
            cmd_wr      <= 1'b0;
            cnt         <= 8'd0;
            rdata       <= 8'd0;
            tout        <= 16'd0;
            rx_rd       <= 1'b0;
            tx_wr       <= 1'b0;
            tx_data     <= 8'd0;
            reg_addr    <= 7'd0;
            reg_wdata   <= 8'd0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            pend        <= pend_n;
            dly         <= dly_n;
            cmd_wr      <= cmd_wr_n;
            cnt         <= cnt_n;
            rdata       <= rdata_n;
            tout        <= tout_n;
            rx_rd       <= rx_rd_n;
            tx_wr       <= tx_wr_n;
            tx_data     <= tx_data_n;
            reg_addr    <= addr_n;
            reg_wdata   <= wdata_n;
            reg_we      <= reg_we_n;
            reg_re      <= reg_re_n;
            timeout_err <= err_n;
        end
    end
endmodule
